// File: rtl/quotient_check_if.sv
// Handshake and operand/result bundle for the quotient back-multiply checker.
interface quotient_check_if #(
    parameter int unsigned WIDTH = 30
);
    logic             start;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] denominator;
    logic [WIDTH-1:0] numerator;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] qd;
    logic             rem_sign;
    logic             rem_zero;
    logic             ovf;

    modport master (
        output start, quotient, denominator, numerator,
        input  busy, done, qd, rem_sign, rem_zero, ovf
    );

    modport slave (
        input  start, quotient, denominator, numerator,
        output busy, done, qd, rem_sign, rem_zero, ovf
    );
endinterface

// File: rtl/quotient_check.sv
// Radix-2 shift-add back-multiplier: forms quotient*denominator exactly and
// compares it with the numerator to drive quotient rounding/correction.
module quotient_check #(
    parameter int unsigned WIDTH = 30
) (
    input  logic              clk,
    input  logic              reset,
    quotient_check_if.slave   bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned FRAC  = WIDTH - 2;

    typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] num_q;
    logic [CNT_W-1:0] cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] qd_q;
    logic             rem_sign_q;
    logic             rem_zero_q;
    logic             ovf_q;

    // Numerator aligned to the product's binary point, compared at full width
    logic [PW-1:0]    target_c;
    assign target_c = {2'b00, num_q, {FRAC{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            num_q      <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            qd_q       <= '0;
            rem_sign_q <= 1'b0;
            rem_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                // IDLE and DONE both accept a new request; done is a one-cycle pulse
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        mcand  <= PW'(bus.denominator);
                        mplier <= bus.quotient;
                        num_q  <= bus.numerator;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end else begin
                        state  <= IDLE;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    qd_q       <= acc[PW-3:FRAC];
                    rem_sign_q <= (acc > target_c);
                    rem_zero_q <= (acc == target_c);
                    ovf_q      <= |acc[PW-1:PW-2];
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.qd       = qd_q;
    assign bus.rem_sign = rem_sign_q;
    assign bus.rem_zero = rem_zero_q;
    assign bus.ovf      = ovf_q;
endmodule
